// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: next-PC selection, imem handshake, decode hand-off and redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        id_ready,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic        misalign_err_q, misalign_err_d;
  logic        tgt_misaligned;
  logic [31:0] eff_target;

  always_comb begin
    tgt_misaligned = (redirect_target[1:0] != 2'b00);
    eff_target     = tgt_misaligned ? TRAP_VECTOR : redirect_target;
    state_d        = state_q;
    pc_next        = pc_cur;
    inst_out_d     = inst_out_q;
    misalign_err_d = redirect_valid && tgt_misaligned;

    case (state_q)
      S_IDLE: begin
        pc_next = redirect_valid ? eff_target : RESET_VECTOR;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_next = eff_target;
          if (imem_gnt) state_d = S_DROP;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_next = eff_target;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          inst_out_d = imem_rdata;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_next = eff_target;
          state_d = S_REQ;
        end else if (id_ready) begin
          pc_next = pc_cur + 32'd4;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_next = eff_target;
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    inst_valid_d = (state_d == S_HOLD);
    if (res) pc_next = RESET_VECTOR;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q        <= S_IDLE;
      inst_valid_q   <= 1'b0;
      inst_out_q     <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      inst_valid_q   <= inst_valid_d;
      inst_out_q     <= inst_out_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign imem_req     = (state_q == S_REQ);
  assign imem_addr    = pc_cur;
  assign inst_valid   = inst_valid_q;
  assign inst_out     = inst_out_q;
  assign inst_pc      = pc_cur;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and instruction memory modelled here, flag-based reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] pc_cur = '0;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        id_ready;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_VECTOR(RV),
    .TRAP_VECTOR (TV)
  ) dut (
    .clk            (clk),
    .res            (res),
    .pc_cur         (pc_cur),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .id_ready       (id_ready),
    .misalign_err   (misalign_err)
  );

  // PC register owned by the surrounding core
  always @(posedge clk) pc_cur <= pc_next;

  int n_vec = 0;
  int n_err = 0;

  // instruction memory
  logic        mem_busy = 1'b0;
  int unsigned mem_wait = 0;
  logic [31:0] mem_addr = '0;
  int unsigned lat_min  = 0;
  int unsigned lat_max  = 0;
  logic        spur_en  = 1'b0;

  // reference model: boot cycle, accepted fetch pending, pending fetch stale, word held for decode
  logic        m_boot  = 1'b1;
  logic        m_busy  = 1'b0;
  logic        m_disc  = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_mis   = 1'b0;
  logic [31:0] m_inst  = '0;
  logic [31:0] m_pc    = RV;
  logic [31:0] exp_pc_next;
  logic        exp_req;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] eff(input logic [31:0] t);
    return (t[1:0] == 2'b00) ? t : TV;
  endfunction

  task automatic eval_model();
    exp_req = !m_boot && !m_busy && !m_valid;
    if (res)                       exp_pc_next = RV;
    else if (m_boot)               exp_pc_next = redirect_valid ? eff(redirect_target) : RV;
    else if (redirect_valid)       exp_pc_next = eff(redirect_target);
    else if (m_valid && id_ready)  exp_pc_next = m_pc + 32'd4;
    else                           exp_pc_next = m_pc;
  endtask

  task automatic look();
    @(negedge clk);
    eval_model();
  endtask

  task automatic adv();
    logic        acc, rv;
    logic [31:0] acc_addr, rdat, n_pc, n_inst;
    logic        n_boot, n_busy, n_disc, n_valid, n_mis;
    eval_model();
    acc = imem_req && imem_gnt;
    acc_addr = imem_addr;
    rv = imem_rvalid;
    rdat = imem_rdata;
    n_pc = exp_pc_next;
    n_boot = m_boot; n_busy = m_busy; n_disc = m_disc; n_valid = m_valid; n_inst = m_inst;
    n_mis = redirect_valid && (redirect_target[1:0] != 2'b00);
    if (m_boot) begin
      n_boot = 1'b0;
    end else if (m_valid) begin
      if (redirect_valid || id_ready) n_valid = 1'b0;
    end else if (m_busy) begin
      if (rv) begin
        n_busy = 1'b0;
        n_disc = 1'b0;
        if (!m_disc && !redirect_valid) begin
          n_valid = 1'b1;
          n_inst  = rdat;
        end
      end else if (redirect_valid) begin
        n_disc = 1'b1;
      end
    end else if (imem_gnt) begin
      n_busy = 1'b1;
      n_disc = redirect_valid;
    end
    @(posedge clk);
    #1;
    if (res) begin
      m_boot = 1'b1; m_busy = 1'b0; m_disc = 1'b0; m_valid = 1'b0;
      m_inst = '0; m_mis = 1'b0; m_pc = RV;
      mem_busy = 1'b0; mem_wait = 0;
    end else begin
      m_boot = n_boot; m_busy = n_busy; m_disc = n_disc; m_valid = n_valid;
      m_inst = n_inst; m_mis = n_mis; m_pc = n_pc;
      if (rv && mem_busy && mem_wait == 0) mem_busy = 1'b0;
      if (acc) begin
        mem_busy = 1'b1;
        mem_addr = acc_addr;
        mem_wait = $urandom_range(lat_max, lat_min);
      end else if (mem_busy && mem_wait > 0) begin
        mem_wait = mem_wait - 1;
      end
    end
    imem_rvalid = mem_busy && (mem_wait == 0);
    imem_rdata  = mem_busy ? memf(mem_addr) : $urandom;
    if (!mem_busy && spur_en && ($urandom_range(3, 0) == 0)) imem_rvalid = 1'b1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    look();
    adv();
    res = 1'b0;
  endtask

  task automatic wait_hold(output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      look();
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
      adv();
    end
  endtask

  task automatic test_reset();
    res = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
    look();
    n_vec++; if (pc_next !== RV) begin n_err++; $display("FAIL rst_pc_next got %h exp %h", pc_next, RV); end
    adv();
    res = 1'b0;
    look();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
    n_vec++; if (inst_out !== 32'h0) begin n_err++; $display("FAIL rst_inst got %h exp 0", inst_out); end
    n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL rst_mis got %b exp 0", misalign_err); end
    n_vec++; if (pc_next !== RV) begin n_err++; $display("FAIL idle_pc_next got %h exp %h", pc_next, RV); end
    adv();
  endtask

  task automatic test_sequential();
    logic [31:0] pcs[3];
    int          at[3];
    int unsigned k = 0;
    lat_min = 0; lat_max = 0; imem_gnt = 1'b1; id_ready = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      look();
      if (inst_valid && k < 3) begin
        pcs[k] = inst_pc;
        at[k]  = cyc;
        n_vec++; if (inst_out !== memf(inst_pc)) begin n_err++; $display("FAIL seq_inst got %h exp %h", inst_out, memf(inst_pc)); end
        k++;
      end
      adv();
    end
    n_vec++;
    if (k < 3) begin
      n_err++; $display("FAIL seq_timeout got %0d instructions exp 3", k);
    end else begin
      n_vec++; if (at[0] !== 3) begin n_err++; $display("FAIL seq_first_cycle got %0d exp 3", at[0]); end
      for (int unsigned i = 0; i < 3; i++) begin
        n_vec++; if (pcs[i] !== 32'(4 * i)) begin n_err++; $display("FAIL seq_pc got %h exp %h", pcs[i], 32'(4 * i)); end
        if (i > 0) begin
          n_vec++; if (at[i] - at[i-1] !== 3) begin n_err++; $display("FAIL seq_gap got %0d exp 3", at[i] - at[i-1]); end
        end
      end
    end
  endtask

  task automatic test_stall();
    bit          ok;
    logic [31:0] v_inst, v_pc;
    lat_min = 0; lat_max = 0; imem_gnt = 1'b1; id_ready = 1'b0;
    do_reset();
    wait_hold(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_timeout got no inst_valid exp inst_valid"); end
    v_inst = inst_out;
    v_pc   = pc_cur;
    for (int unsigned i = 0; i < 5; i++) begin
      if (i > 0) look();
      n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid got %b exp 1", inst_valid); end
      n_vec++; if (inst_out !== v_inst) begin n_err++; $display("FAIL stall_inst got %h exp %h", inst_out, v_inst); end
      n_vec++; if (pc_next !== v_pc) begin n_err++; $display("FAIL stall_pc_next got %h exp %h", pc_next, v_pc); end
      n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req got %b exp 0", imem_req); end
      adv();
    end
    id_ready = 1'b1;
    look();
    n_vec++; if (pc_next !== v_pc + 32'd4) begin n_err++; $display("FAIL stall_release got %h exp %h", pc_next, v_pc + 32'd4); end
    adv();
  endtask

  task automatic test_redirect_wait();
    bit ok = 1'b0;
    lat_min = 2; lat_max = 2; imem_gnt = 1'b1; id_ready = 1'b1;
    do_reset();
    for (int unsigned i = 0; i < 10; i++) begin
      look();
      if (imem_req) begin ok = 1'b1; break; end
      adv();
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL rw_req_timeout got no request exp request"); end
    adv();
    lat_min = 0; lat_max = 0;
    redirect_valid = 1'b1; redirect_target = 32'h100;
    look();
    n_vec++; if (pc_next !== 32'h100) begin n_err++; $display("FAIL rw_pc_next got %h exp 100", pc_next); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rw_req got %b exp 0", imem_req); end
    adv();
    redirect_valid = 1'b0;
    ok = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      look();
      n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rw_dropped got inst_valid %b exp 0", inst_valid); end
      if (imem_req) begin
        ok = 1'b1;
        n_vec++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL rw_addr got %h exp 100", imem_addr); end
        break;
      end
      adv();
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL rw_drop_timeout got no request exp request"); end
    adv();
    wait_hold(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rw_hold_timeout got no inst_valid exp inst_valid"); end
    n_vec++; if (inst_pc !== 32'h100) begin n_err++; $display("FAIL rw_inst_pc got %h exp 100", inst_pc); end
    n_vec++; if (inst_out !== memf(32'h100)) begin n_err++; $display("FAIL rw_inst got %h exp %h", inst_out, memf(32'h100)); end
    adv();
  endtask

  task automatic test_redirect_hold();
    bit ok;
    lat_min = 0; lat_max = 0; imem_gnt = 1'b1; id_ready = 1'b0;
    do_reset();
    wait_hold(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rh_timeout got no inst_valid exp inst_valid"); end
    adv();
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    look();
    n_vec++; if (pc_next !== 32'h200) begin n_err++; $display("FAIL rh_pc_next got %h exp 200", pc_next); end
    adv();
    redirect_valid = 1'b0;
    look();
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rh_valid got %b exp 0", inst_valid); end
    n_vec++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL rh_addr got %h exp 200", imem_addr); end
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rh_req got %b exp 1", imem_req); end
    adv();
  endtask

  task automatic test_misalign();
    bit ok;
    lat_min = 0; lat_max = 0; imem_gnt = 1'b1; id_ready = 1'b0;
    do_reset();
    wait_hold(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL mis_timeout got no inst_valid exp inst_valid"); end
    adv();
    redirect_valid = 1'b1; redirect_target = 32'h102;
    look();
    n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_early got %b exp 0", misalign_err); end
    adv();
    redirect_valid = 1'b0;
    look();
    n_vec++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_pulse got %b exp 1", misalign_err); end
    n_vec++; if (imem_addr !== TV) begin n_err++; $display("FAIL mis_addr got %h exp %h", imem_addr, TV); end
    adv();
    look();
    n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_width got %b exp 0", misalign_err); end
    adv();
  endtask

  task automatic test_wrap_reset();
    bit ok;
    lat_min = 0; lat_max = 0; imem_gnt = 1'b1; id_ready = 1'b0;
    do_reset();
    wait_hold(ok);
    adv();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    look();
    adv();
    redirect_valid = 1'b0;
    wait_hold(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_timeout got no inst_valid exp inst_valid"); end
    n_vec++; if (inst_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_inst_pc got %h exp fffffffc", inst_pc); end
    adv();
    id_ready = 1'b1;
    look();
    n_vec++; if (pc_next !== 32'h0) begin n_err++; $display("FAIL wrap_pc_next got %h exp 0", pc_next); end
    adv();
    id_ready = 1'b0; lat_min = 2; lat_max = 2;
    look();
    n_vec++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_req got %h/%b exp 0/1", imem_addr, imem_req); end
    adv();
    res = 1'b1;
    look();
    adv();
    res = 1'b0;
    look();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL midrst_req got %b exp 0", imem_req); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b exp 0", inst_valid); end
    n_vec++; if (pc_next !== RV) begin n_err++; $display("FAIL midrst_pc_next got %h exp %h", pc_next, RV); end
    adv();
    look();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== RV) begin n_err++; $display("FAIL midrst_refetch got %b/%h exp 1/%h", imem_req, imem_addr, RV); end
    adv();
  endtask

  task automatic test_random();
    lat_min = 0; lat_max = 3; spur_en = 1'b1;
    do_reset();
    for (int unsigned i = 0; i < 4000; i++) begin
      res            = ($urandom_range(99, 0) == 0);
      imem_gnt       = ($urandom_range(1, 0) == 1);
      id_ready       = ($urandom_range(2, 0) != 0);
      redirect_valid = ($urandom_range(9, 0) == 0);
      redirect_target = $urandom;
      if ($urandom_range(3, 0) != 0) redirect_target[1:0] = 2'b00;
      look();
      n_vec++; if (pc_next !== exp_pc_next) begin n_err++; $display("FAIL rnd_pc_next @%0d got %h exp %h", i, pc_next, exp_pc_next); end
      n_vec++; if (imem_req !== exp_req) begin n_err++; $display("FAIL rnd_req @%0d got %b exp %b", i, imem_req, exp_req); end
      n_vec++; if (imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr @%0d got %h exp %h", i, imem_addr, m_pc); end
      n_vec++; if (inst_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid @%0d got %b exp %b", i, inst_valid, m_valid); end
      n_vec++; if (misalign_err !== m_mis) begin n_err++; $display("FAIL rnd_mis @%0d got %b exp %b", i, misalign_err, m_mis); end
      if (m_valid) begin
        n_vec++; if (inst_out !== m_inst) begin n_err++; $display("FAIL rnd_inst @%0d got %h exp %h", i, inst_out, m_inst); end
        n_vec++; if (inst_pc !== m_pc) begin n_err++; $display("FAIL rnd_inst_pc @%0d got %h exp %h", i, inst_pc, m_pc); end
      end
      adv();
    end
    res = 1'b0; spur_en = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    res = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_target = '0; id_ready = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_misalign();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got time limit exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the RV32I core. It owns the next-PC selection feeding the PC register's `in` port and reads back the PC register's `out`. It runs the request/grant/response handshake to instruction memory, holds the fetched word until decode accepts it, and applies branch/jump redirects, discarding any in-flight fetch made stale by a redirect.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.
- `TRAP_VECTOR`, default 32'h0000_0010: address substituted for a misaligned redirect target.

Ports:
- `clk` input 1: single clock; everything is on the rising edge.
- `res` input 1: synchronous, active-high reset.
- `pc_cur` input 32: current value of the PC register (its `out`).
- `pc_next` output 32: next value of the PC register (its `in`), combinational.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch address, equal to `pc_cur`.
- `imem_gnt` input 1: the request is accepted in a cycle where `imem_req && imem_gnt`.
- `imem_rvalid` input 1: response valid, at least 1 cycle after acceptance.
- `imem_rdata` input 32: response data.
- `redirect_valid` input 1: a taken branch, JAL or JALR this cycle.
- `redirect_target` input 32: target address.
- `inst_valid` output 1: registered; the instruction is presented to decode.
- `inst_out` output 32: registered instruction word.
- `inst_pc` output 32: address of `inst_out`, equal to `pc_cur` while `inst_valid` is high.
- `id_ready` input 1: decode accepts the instruction when `inst_valid && id_ready`.
- `misalign_err` output 1: registered, one-cycle pulse for a misaligned redirect target.

## Operation
- At most one outstanding memory request at any time.
- The FSM has five states: IDLE, REQ, WAIT, HOLD, DROP.
- **Effective target:**
  - If `redirect_target[1:0] == 0`, the effective target is `redirect_target`.
  - Otherwise it is `TRAP_VECTOR`, and `misalign_err` pulses in the next cycle.
- **IDLE** (entered from reset, lasts 1 cycle):
  - `pc_next = RESET_VECTOR`, or the effective target if `redirect_valid` is high.
  - Next state is REQ.
- **REQ:** `imem_req = 1`.
  - Grant, no redirect: go to WAIT; `pc_next = pc_cur`.
  - Redirect, no grant: `pc_next` = effective target; stay in REQ. The new address is presented next cycle and the unaccepted request is abandoned.
  - Redirect and grant in the same cycle: `pc_next` = effective target; go to DROP.
  - Otherwise: stay in REQ; `pc_next = pc_cur`.
- **WAIT:** `imem_req = 0`.
  - `imem_rvalid`, no redirect: capture `imem_rdata` into `inst_out`; go to HOLD.
  - Redirect and `imem_rvalid` in the same cycle: discard the data; `pc_next` = effective target; go to REQ.
  - Redirect, no `imem_rvalid`: `pc_next` = effective target; go to DROP.
  - Otherwise: hold; `pc_next = pc_cur`.
- **HOLD:** `inst_valid = 1`.
  - Redirect has priority over transfer: the instruction is dropped; `pc_next` = effective target; go to REQ.
  - Transfer (`id_ready`), no redirect: `pc_next = pc_cur + 4`, modulo 2^32 (0xFFFF_FFFC wraps to 0); go to REQ.
  - Otherwise: hold; `inst_out`, `inst_pc` and `pc_next = pc_cur` are unchanged.
- **DROP:** `imem_req = 0`.
  - On `imem_rvalid`: discard the data; go to REQ.
  - A further redirect while in DROP updates `pc_next` to the new effective target and stays in DROP.
- `imem_rvalid` outside WAIT and DROP is ignored.

## Timing
- **Reset values:**
  - state IDLE
  - `inst_valid` = 0, `inst_out` = 0, `misalign_err` = 0, `imem_req` = 0
  - `pc_next` = `RESET_VECTOR` during the reset cycle
- A reset asserted mid-operation aborts everything in 1 cycle. Instruction memory shares `res`, so no stale response arrives after reset.
- **Fetch latency** with an immediate grant and a 1-cycle memory:
  - REQ in cycle n, WAIT in n+1 with `rvalid`, `inst_valid` high in n+2.
  - Back-to-back throughput is 1 instruction per 3 cycles.
- A redirect takes effect on `pc_cur` in the next cycle. The first request to the target is issued in that cycle, or after the discarded response if the FSM went to DROP.
- `inst_valid` falls in the cycle after a transfer or a redirect. It never stays high for an instruction that was already accepted.

## Test plan
- **Reset and sequential fetch:** release `res` with `RESET_VECTOR` = 0x0, permanent grant, 1-cycle memory, `id_ready` = 1 -> `inst_pc` is 0x0, 0x4, 0x8, each appearing 3 cycles apart.
- **Decode stall:** `id_ready` = 0 for 5 cycles while in HOLD -> `inst_valid`, `inst_out` and `pc_next` are stable; `imem_req` = 0. Raising `id_ready` gives `pc_next = pc_cur + 4`.
- **Redirect during WAIT without rvalid:** target 0x100 -> DROP; the next `rvalid` data is not presented; the next `imem_addr` is 0x100; the following `inst_pc` is 0x100.
- **Redirect and transfer in the same HOLD cycle:** target 0x200 -> `pc_next` = 0x200, not +4; `inst_valid` = 0 next cycle.
- **Misaligned redirect:** target 0x102 -> `misalign_err` pulses for exactly 1 cycle; the next fetch address is `TRAP_VECTOR` (0x10).
- **Wrap and mid-fetch reset:** accept an instruction at 0xFFFF_FFFC -> the next address is 0x0. Then assert `res` in WAIT -> next cycle state is IDLE, `inst_valid` = 0, `imem_req` = 0.
